// File: rtl/frame_sequencer_if.sv
// Bus between the game-loop sequencer and the gameplay datapath.
// master : sequencer side (drives phase strobes and status, receives dones).
// slave  : datapath side (drives dones and map_redraw, receives strobes).
// Signals:
//   idle_done, check_collide_done, draw_map_done, draw_link_done,
//   draw_enemies_done : done levels from the datapath
//   map_redraw        : one-cycle request to repaint the map next frame
//   init .. draw_enemies : one-hot phase strobes
//   frame_count [15:0], timeout_err, state_dbg [3:0] : status
interface frame_sequencer_if;
  logic        idle_done;
  logic        check_collide_done;
  logic        draw_map_done;
  logic        draw_link_done;
  logic        draw_enemies_done;
  logic        map_redraw;

  logic        init;
  logic        idle;
  logic        gen_move;
  logic        check_collide;
  logic        apply_act_link;
  logic        move_enemies;
  logic        draw_map;
  logic        draw_link;
  logic        draw_enemies;
  logic [15:0] frame_count;
  logic        timeout_err;
  logic [3:0]  state_dbg;

  modport master (
    input  idle_done, check_collide_done, draw_map_done, draw_link_done,
           draw_enemies_done, map_redraw,
    output init, idle, gen_move, check_collide, apply_act_link, move_enemies,
           draw_map, draw_link, draw_enemies, frame_count, timeout_err, state_dbg
  );

  modport slave (
    output idle_done, check_collide_done, draw_map_done, draw_link_done,
           draw_enemies_done, map_redraw,
    input  init, idle, gen_move, check_collide, apply_act_link, move_enemies,
           draw_map, draw_link, draw_enemies, frame_count, timeout_err, state_dbg
  );
endinterface

// File: rtl/frame_sequencer.sv
// Game-loop controller: steps the datapath through one frame of phases
// (idle, move gen, collision, apply, enemy move, map draw, Link draw,
// enemy draw) using one-hot Moore strobes, waits on done levels, and
// forces progress with a watchdog if a done never arrives.
// Ports:
//   clock : system clock
//   reset : asynchronous, active-high reset
//   bus   : frame_sequencer_if.master (dones in, strobes/status out)
// Parameters:
//   INIT_CYCLES : cycles spent in S_INIT after reset release (min 1)
//   WAIT_LIMIT  : max cycles in a done-wait phase before forced advance
module frame_sequencer #(
  parameter logic [3:0]  INIT_CYCLES = 4'd2,
  parameter logic [23:0] WAIT_LIMIT  = 24'd2_000_000
) (
  input  logic              clock,
  input  logic              reset,
  frame_sequencer_if.master bus
);

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_IDLE   = 4'd1,
    S_GEN    = 4'd2,
    S_COLL   = 4'd3,
    S_APPLY  = 4'd4,
    S_EMOVE  = 4'd5,
    S_DMAP   = 4'd6,
    S_DLINK  = 4'd7,
    S_DENEMY = 4'd8
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  init_cnt_q, init_cnt_d;
  logic [23:0] wait_cnt_q, wait_cnt_d;
  logic [15:0] frame_count_q, frame_count_d;
  logic        map_pending_q, map_pending_d;
  logic        timeout_err_q, timeout_err_d;

  logic        cur_done;
  logic        wait_phase;
  logic        limit_hit;
  logic        exit_ok;

  // State register and all other flops; reset returns to S_INIT at once.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= S_INIT;
      init_cnt_q    <= 4'd0;
      wait_cnt_q    <= 24'd0;
      frame_count_q <= 16'd0;
      map_pending_q <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      init_cnt_q    <= init_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
      frame_count_q <= frame_count_d;
      map_pending_q <= map_pending_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Select the done level that the current watched phase is waiting on.
  always_comb begin
    cur_done   = 1'b0;
    wait_phase = 1'b0;
    case (state_q)
      S_COLL: begin
        cur_done   = bus.check_collide_done;
        wait_phase = 1'b1;
      end
      S_DMAP: begin
        cur_done   = bus.draw_map_done;
        wait_phase = 1'b1;
      end
      S_DLINK: begin
        cur_done   = bus.draw_link_done;
        wait_phase = 1'b1;
      end
      S_DENEMY: begin
        cur_done   = bus.draw_enemies_done;
        wait_phase = 1'b1;
      end
      default: ;
    endcase
  end

  // The watchdog fires on the last allowed cycle of a watched phase and
  // takes the same exit a real done would have taken.
  assign limit_hit = wait_phase && (wait_cnt_q == (WAIT_LIMIT - 24'd1));
  assign exit_ok   = cur_done || limit_hit;

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT:   if (init_cnt_q == (INIT_CYCLES - 4'd1)) state_d = S_DMAP;
      S_IDLE:   if (bus.idle_done) state_d = S_GEN;
      S_GEN:    state_d = S_COLL;
      S_COLL:   if (exit_ok) state_d = S_APPLY;
      S_APPLY:  state_d = S_EMOVE;
      S_EMOVE:  state_d = map_pending_q ? S_DMAP : S_DLINK;
      S_DMAP:   if (exit_ok) state_d = S_DLINK;
      S_DLINK:  if (exit_ok) state_d = S_DENEMY;
      S_DENEMY: if (exit_ok) state_d = S_IDLE;
      default:  state_d = S_INIT;
    endcase
  end

  // Counters and flags. A map_redraw request is applied after the S_DMAP
  // exit clear so a request on the exit cycle survives into the next frame.
  always_comb begin
    init_cnt_d    = init_cnt_q;
    map_pending_d = map_pending_q;
    wait_cnt_d    = wait_cnt_q;
    frame_count_d = frame_count_q;
    timeout_err_d = timeout_err_q | (limit_hit & ~cur_done);

    if (state_q == S_INIT) begin
      init_cnt_d    = init_cnt_q + 4'd1;
      map_pending_d = 1'b1;
    end
    if ((state_q == S_DMAP) && (state_d != S_DMAP)) map_pending_d = 1'b0;
    if (bus.map_redraw) map_pending_d = 1'b1;

    if (state_d != state_q) begin
      wait_cnt_d = 24'd0;
    end else if (wait_phase) begin
      wait_cnt_d = wait_cnt_q + 24'd1;
    end

    if ((state_q == S_DENEMY) && (state_d == S_IDLE)) begin
      frame_count_d = frame_count_q + 16'd1;
    end
  end

  // Moore outputs decoded from the registered state only.
  always_comb begin
    bus.init           = 1'b0;
    bus.idle           = 1'b0;
    bus.gen_move       = 1'b0;
    bus.check_collide  = 1'b0;
    bus.apply_act_link = 1'b0;
    bus.move_enemies   = 1'b0;
    bus.draw_map       = 1'b0;
    bus.draw_link      = 1'b0;
    bus.draw_enemies   = 1'b0;
    case (state_q)
      S_INIT:   bus.init           = 1'b1;
      S_IDLE:   bus.idle           = 1'b1;
      S_GEN:    bus.gen_move       = 1'b1;
      S_COLL:   bus.check_collide  = 1'b1;
      S_APPLY:  bus.apply_act_link = 1'b1;
      S_EMOVE:  bus.move_enemies   = 1'b1;
      S_DMAP:   bus.draw_map       = 1'b1;
      S_DLINK:  bus.draw_link      = 1'b1;
      S_DENEMY: bus.draw_enemies   = 1'b1;
      default:  bus.init           = 1'b1;
    endcase
    bus.state_dbg   = state_q;
    bus.frame_count = frame_count_q;
    bus.timeout_err = timeout_err_q;
  end

endmodule

// File: tb/tb_frame_sequencer.sv
// Self-checking bench for frame_sequencer. A phase-level model predicts
// strobes, frame count, watchdog flag and state code each cycle; directed
// scenarios add hand-computed literal checks.
module tb_frame_sequencer;

  localparam logic [3:0]  INIT_C = 4'd2;
  localparam logic [23:0] WLIM   = 24'd16;

  localparam int P_INIT   = 0;
  localparam int P_IDLE   = 1;
  localparam int P_GEN    = 2;
  localparam int P_COLL   = 3;
  localparam int P_APPLY  = 4;
  localparam int P_EMOVE  = 5;
  localparam int P_DMAP   = 6;
  localparam int P_DLINK  = 7;
  localparam int P_DENEMY = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic check_en = 1'b0;
  logic frame_preload = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  frame_sequencer_if bus();

  frame_sequencer #(
    .INIT_CYCLES(INIT_C),
    .WAIT_LIMIT (WLIM)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  // Phase-level model of one frame.
  typedef struct {
    int          phase;
    int          dwell;
    int          init_cycles;
    logic        map;
    logic        tmo;
    logic [15:0] frames;
  } model_t;

  localparam model_t MODEL_RESET = '{phase: 0, dwell: 1, init_cycles: 0,
                                     map: 1'b0, tmo: 1'b0, frames: 16'd0};

  model_t m = MODEL_RESET;

  function automatic model_t model_step(model_t cur, logic i_idle, logic i_coll,
                                        logic i_dmap, logic i_dlink,
                                        logic i_denemy, logic i_redraw,
                                        logic i_preload);
    model_t nx;
    logic   done;
    int     follow;
    nx     = cur;
    done   = 1'b0;
    follow = cur.phase;
    case (cur.phase)
      P_INIT: begin
        nx.map = 1'b1;
        nx.init_cycles = cur.init_cycles + 1;
        if (nx.init_cycles >= int'(INIT_C)) nx.phase = P_DMAP;
      end
      P_IDLE:  if (i_idle) nx.phase = P_GEN;
      P_GEN:   nx.phase = P_COLL;
      P_APPLY: nx.phase = P_EMOVE;
      P_EMOVE: nx.phase = cur.map ? P_DMAP : P_DLINK;
      default: begin
        case (cur.phase)
          P_COLL:  begin done = i_coll;   follow = P_APPLY;  end
          P_DMAP:  begin done = i_dmap;   follow = P_DLINK;  end
          P_DLINK: begin done = i_dlink;  follow = P_DENEMY; end
          default: begin done = i_denemy; follow = P_IDLE;   end
        endcase
        if (!done && cur.dwell >= int'(WLIM)) begin
          done   = 1'b1;
          nx.tmo = 1'b1;
        end
        if (done) nx.phase = follow;
      end
    endcase
    if (cur.phase == P_DMAP && nx.phase != P_DMAP) nx.map = 1'b0;
    if (cur.phase == P_DENEMY && nx.phase == P_IDLE) nx.frames = cur.frames + 16'd1;
    if (i_redraw) nx.map = 1'b1;
    if (i_preload) nx.frames = 16'hFFFF;
    nx.dwell = (nx.phase != cur.phase) ? 1 : cur.dwell + 1;
    return nx;
  endfunction

  // Advance the model on every clock edge; reset is asynchronous as in the DUT.
  always @(posedge clock or posedge reset) begin
    if (reset) m <= MODEL_RESET;
    else m <= model_step(m, bus.idle_done, bus.check_collide_done,
                         bus.draw_map_done, bus.draw_link_done,
                         bus.draw_enemies_done, bus.map_redraw, frame_preload);
  end

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: simulation still running at %0t, required finish", $time);
    $fatal(1, "[TB] global timeout");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic i_idle, input logic i_coll,
                               input logic i_dmap, input logic i_dlink,
                               input logic i_denemy, input logic i_redraw);
    bus.idle_done          = i_idle;
    bus.check_collide_done = i_coll;
    bus.draw_map_done      = i_dmap;
    bus.draw_link_done     = i_dlink;
    bus.draw_enemies_done  = i_denemy;
    bus.map_redraw         = i_redraw;
  endtask

  task automatic waitState(input logic [3:0] s, input string name);
    int guard;
    guard = 0;
    while (bus.state_dbg != s && guard < 200) begin
      @(negedge clock);
      guard++;
    end
    if (bus.state_dbg != s) checkOutput({name, "_wait"}, 32'(bus.state_dbg), 32'(s));
  endtask

  task automatic waitIdleCount(input logic [15:0] n, input string name);
    int guard;
    guard = 0;
    while (!(bus.state_dbg == 4'd1 && bus.frame_count == n) && guard < 400) begin
      @(negedge clock);
      guard++;
    end
    if (bus.frame_count != n) checkOutput({name, "_wait"}, 32'(bus.frame_count), 32'(n));
  endtask

  // Runs until frame_count changes, counting cycles with draw_map high.
  task automatic runFrame(input logic pulse_at_dmap, input string name,
                          output int dmap_cycles);
    logic [15:0] start;
    int          guard;
    logic        pulsed;
    start       = bus.frame_count;
    dmap_cycles = 0;
    pulsed      = 1'b0;
    guard       = 0;
    while (bus.frame_count == start && guard < 200) begin
      @(negedge clock);
      guard++;
      bus.map_redraw = 1'b0;
      if (bus.draw_map) begin
        dmap_cycles++;
        if (pulse_at_dmap && !pulsed) begin
          bus.map_redraw = 1'b1;
          pulsed = 1'b1;
        end
      end
    end
    if (bus.frame_count == start)
      checkOutput({name, "_frame_wait"}, 32'(bus.frame_count), 32'(start + 16'd1));
  endtask

  int          cnt;
  int          visits;
  logic [3:0]  t1_exp [12] = '{4'd0, 4'd0, 4'd6, 4'd7, 4'd8, 4'd1,
                               4'd2, 4'd3, 4'd4, 4'd5, 4'd7, 4'd8};

  initial begin
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);

    fork
      forever begin
        @(negedge clock);
        if (check_en) begin
          checkOutput("cyc_strobes",
                      32'({bus.draw_enemies, bus.draw_link, bus.draw_map,
                           bus.move_enemies, bus.apply_act_link, bus.check_collide,
                           bus.gen_move, bus.idle, bus.init}),
                      32'(9'b1 << m.phase));
          checkOutput("cyc_frame_count", 32'(bus.frame_count), 32'(m.frames));
          checkOutput("cyc_timeout_err", 32'(bus.timeout_err), 32'(m.tmo));
          checkOutput("cyc_state_dbg", 32'(bus.state_dbg), 32'(m.phase));
        end
      end
    join_none

    repeat (3) @(negedge clock);
    check_en = 1'b1;
    checkOutput("reset_state_dbg", 32'(bus.state_dbg), 32'd0);
    checkOutput("reset_init", 32'(bus.init), 32'd1);
    checkOutput("reset_frame_count", 32'(bus.frame_count), 32'd0);
    checkOutput("reset_timeout_err", 32'(bus.timeout_err), 32'd0);

    $display("[TB] scenario 1: first frame after reset release");
    reset = 1'b0;
    #1;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) begin
        @(negedge clock);
        #1;
      end
      checkOutput($sformatf("t1_state_%0d", i), 32'(bus.state_dbg), 32'(t1_exp[i]));
      if (i == 4) checkOutput("t1_count_before_exit", 32'(bus.frame_count), 32'd0);
      if (i == 5) checkOutput("t1_count_after_exit", 32'(bus.frame_count), 32'd1);
    end

    $display("[TB] scenario 2: draw_link_done delayed 10 cycles");
    waitState(4'd1, "t2_idle");
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    waitState(4'd7, "t2_dlink");
    cnt = 1;
    repeat (10) begin
      @(negedge clock);
      if (bus.draw_link) cnt++;
    end
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    @(negedge clock);
    checkOutput("t2_dlink_cycles", 32'(cnt), 32'd11);
    checkOutput("t2_next_state", 32'(bus.state_dbg), 32'd8);

    $display("[TB] scenario 3: map_redraw requests");
    waitIdleCount(16'd4, "t3_frame5");
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    runFrame(1'b0, "t3_f5", visits);
    checkOutput("t3_frame5_dmap", 32'(visits), 32'd1);
    runFrame(1'b0, "t3_f6", visits);
    checkOutput("t3_frame6_dmap", 32'(visits), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    runFrame(1'b1, "t3_f7", visits);
    checkOutput("t3_frame7_dmap", 32'(visits), 32'd1);
    runFrame(1'b0, "t3_f8", visits);
    checkOutput("t3_frame8_dmap_after_exit_pulse", 32'(visits), 32'd1);
    runFrame(1'b0, "t3_f9", visits);
    checkOutput("t3_frame9_dmap", 32'(visits), 32'd0);

    $display("[TB] scenario 4: watchdog on stuck check_collide_done");
    checkOutput("t4_timeout_before", 32'(bus.timeout_err), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    waitState(4'd3, "t4_coll");
    cnt = 1;
    for (int g = 0; g < 100; g++) begin
      @(negedge clock);
      if (!bus.check_collide) break;
      cnt++;
    end
    checkOutput("t4_coll_cycles", 32'(cnt), 32'd16);
    checkOutput("t4_after_state", 32'(bus.state_dbg), 32'd4);
    checkOutput("t4_timeout_set", 32'(bus.timeout_err), 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    runFrame(1'b0, "t4_fa", visits);
    runFrame(1'b0, "t4_fb", visits);
    checkOutput("t4_timeout_sticky", 32'(bus.timeout_err), 32'd1);

    $display("[TB] scenario 5: reset during draw_enemies");
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    waitIdleCount(16'd3, "t5_frame4");
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    waitState(4'd8, "t5_denemy");
    checkOutput("t5_count_before_reset", 32'(bus.frame_count), 32'd3);
    @(negedge clock);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("t5_async_state_dbg", 32'(bus.state_dbg), 32'd0);
    checkOutput("t5_async_frame_count", 32'(bus.frame_count), 32'd0);
    checkOutput("t5_async_init", 32'(bus.init), 32'd1);
    checkOutput("t5_async_draw_enemies", 32'(bus.draw_enemies), 32'd0);
    checkOutput("t5_async_timeout", 32'(bus.timeout_err), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    repeat (2) @(negedge clock);
    reset = 1'b0;

    $display("[TB] scenario 6: frame_count wrap");
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    waitState(4'd1, "t6_idle");
    #2;
    force dut.frame_count_q = 16'hFFFF;
    frame_preload = 1'b1;
    @(negedge clock);
    #2;
    release dut.frame_count_q;
    frame_preload = 1'b0;
    checkOutput("t6_preloaded", 32'(bus.frame_count), 32'h0000FFFF);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    runFrame(1'b0, "t6_wrap", visits);
    #1;
    checkOutput("t6_wrapped", 32'(bus.frame_count), 32'd0);

    repeat (3) @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/frame_sequencer.md
# frame_sequencer

Top-level game-loop controller for the gameplay datapath. It drives the datapath's one-hot phase strobes once per frame, in fixed order: idle, move generation, collision check, action apply, enemy move, map draw, Link draw, enemy draw. It waits on the datapath's done levels between phases, and a watchdog keeps a stuck submodule from hanging the loop. The map is redrawn only on the first frame and on request.

## Interface
Parameters:
- INIT_CYCLES, 4'd2: cycles `init` is held after reset release (min 1).
- WAIT_LIMIT, 24'd2_000_000: max cycles in any done-wait phase except IDLE before forced advance.

Ports:
- clock  in  1  system clock (CLOCK_50).
- reset  in  1  asynchronous, active-high reset (SW[9]).
- idle_done  in  1  frame-rate tick from datapath.
- check_collide_done  in  1  collision calc complete.
- draw_map_done, draw_link_done, draw_enemies_done  in  1 each  draw complete levels.
- map_redraw  in  1  single-cycle request to repaint the map next frame.
- init, idle, gen_move, check_collide, apply_act_link, move_enemies, draw_map, draw_link, draw_enemies  out  1 each  phase strobes to datapath.
- frame_count  out  16  completed frames since reset.
- timeout_err  out  1  sticky watchdog flag.
- state_dbg  out  4  current state code.

## Operation
- States and codes: S_INIT=0, S_IDLE=1, S_GEN=2, S_COLL=3, S_APPLY=4, S_EMOVE=5, S_DMAP=6, S_DLINK=7, S_DENEMY=8.
- Outputs are decoded from the registered state only (Moore). Exactly one phase strobe is high in every state: init in S_INIT, idle in S_IDLE, and so on.
- S_INIT stays for INIT_CYCLES cycles after reset release, then goes to S_DMAP. map_pending is set on entry, so the first frame always paints the map.
- S_IDLE leaves to S_GEN on the first cycle idle_done is sampled high.
- S_GEN, S_APPLY and S_EMOVE each last exactly 1 cycle.
- S_GEN -> S_COLL -> (check_collide_done) -> S_APPLY -> S_EMOVE.
- From S_EMOVE: go to S_DMAP if map_pending, else S_DLINK.
- S_DMAP leaves on draw_map_done and clears map_pending.
- S_DLINK leaves on draw_link_done to S_DENEMY. S_DENEMY leaves on draw_enemies_done to S_IDLE.
- The S_DENEMY -> S_IDLE transition increments frame_count (16-bit, wraps 0xFFFF -> 0).
- map_redraw sets map_pending in any state. If map_redraw and the S_DMAP exit happen in the same cycle, the set wins and map_pending stays 1.
- Watchdog: a 24-bit wait_cnt is zeroed on every state change and increments in S_COLL, S_DMAP, S_DLINK and S_DENEMY. When wait_cnt == WAIT_LIMIT-1 and done is still low, the FSM takes the normal exit next edge and sets timeout_err. timeout_err clears only on reset.
- A done that was already high on state entry is accepted (level-sensitive). The datapath must deassert stale dones itself.

## Timing
- Reset (asynchronous) forces: state=S_INIT, init=1, all other strobes=0, frame_count=0, timeout_err=0, map_pending=0, wait_cnt=0, init counter=0, state_dbg=0.
- Reset asserted mid-frame aborts immediately to S_INIT. No partial phase completes.
- Done-to-strobe latency is 1 cycle. The done is sampled at edge N, and the next phase strobe is high after edge N.
- Minimum frame with no map draw and every done already high: IDLE, GEN, COLL, APPLY, EMOVE, DLINK, DENEMY = 7 cycles.

## Test plan
- Reset release, INIT_CYCLES=2, all dones held high → init high for exactly 2 cycles, then draw_map 1 cycle, draw_link 1, draw_enemies 1, idle 1, gen_move 1, check_collide 1, apply_act_link 1, move_enemies 1, draw_link next (no second map draw). frame_count=1 after the first draw_enemies exit.
- Steady state, draw_link_done delayed 10 cycles → draw_link stays high exactly 11 cycles. No other strobe is high meanwhile. Strobes are one-hot every cycle.
- map_redraw pulsed during S_IDLE of frame 5 → S_DMAP visited in frame 5 only. Pulse on the exact S_DMAP exit cycle → S_DMAP visited again next frame.
- WAIT_LIMIT=16, check_collide_done stuck low → check_collide high exactly 16 cycles, then apply_act_link. timeout_err=1 and stays 1 through later frames until reset.
- Reset asserted while in S_DENEMY with frame_count=3 → same-cycle asynchronous return: state_dbg=0, frame_count=0, init=1, draw_enemies=0.
- Force frame_count to 0xFFFF and complete one frame → frame_count reads 0x0000.
